// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_if
// Description : Parallel-side request bus and serial-side status of the UART
//               TX framer.
//                 P_DATA     word to transmit, sampled on accept
//                 Data_Valid send request, honoured only while Busy=0
//                 PAR_EN     1 inserts a parity bit after the data bits
//                 PAR_TYP    0 even parity, 1 odd parity
//                 TX_OUT     serial line, idles high
//                 Busy       high from start bit through stop bit
//               master : the client that requests frames
//               slave  : the framer itself
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART frame serialiser. One bit per CLK (CLK is the baud
//               clock): start bit, DATA_WIDTH data bits LSB first, optional
//               parity bit, stop bit. Parity: PAR_TYP=0 even (^data),
//               PAR_TYP=1 odd (~^data), always taken from the latched word.
//   CLK  in   baud-rate clock, rising edge
//   RST  in   asynchronous active-low reset
//   bus  slave modport of uart_tx_frame_if (P_DATA, Data_Valid, PAR_EN,
//        PAR_TYP in; TX_OUT, Busy out, both registered)
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    uart_tx_frame_if.slave    bus
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_tx;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_tx_nxt;
    logic                   w_busy_nxt;
    logic                   w_accept;
    logic                   w_parity;

    assign w_parity = r_par_typ ? ~^r_data : ^r_data;

    // Outputs are computed for the state being entered and registered with
    // it, so TX_OUT/Busy change exactly on the edge that changes state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_data[0];
                w_busy_nxt  = 1'b1;
            end
            S_DATA: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    if (r_par_en) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = w_parity;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    // Counter stops at c_CNT_LAST, so the index stays in range.
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_tx_nxt  = r_data[w_cnt_nxt];
                end
            end
            S_PARITY: begin
                w_state_nxt = S_STOP;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            S_STOP: begin
                // Busy drops here, forcing at least one idle cycle between
                // frames even when Data_Valid is held high.
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_data    <= bus.P_DATA;
                r_par_en  <= bus.PAR_EN;
                r_par_typ <= bus.PAR_TYP;
            end
        end
    end

    assign bus.TX_OUT = r_tx;
    assign bus.Busy   = r_busy;

endmodule
`default_nettype wire
